// File: rtl/decoding_display.sv
// Four-channel seven-segment decoder with registered, glitch-free outputs.
// Each channel maps a 4-bit digit to a segment pattern (bit0=a .. bit6=g).
// Stage p0 is the combinational decode. Stage p1 is the output register.
module decoding_display #(
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit BLANK_NON_BCD = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] out0,
    input  logic [3:0] out1,
    input  logic [3:0] out2,
    input  logic [3:0] out3,
    output logic [6:0] Hex0,
    output logic [6:0] Hex1,
    output logic [6:0] Hex2,
    output logic [6:0] Hex3
);

    // A dark digit after the polarity inversion has been applied.
    localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

    // Active-high lit-segment glyph for each of the 16 codes.
    function automatic logic [6:0] seg_lit(input logic [3:0] d);
        logic [6:0] lit;
        case (d)
            4'h0:    lit = 7'h3F;
            4'h1:    lit = 7'h06;
            4'h2:    lit = 7'h5B;
            4'h3:    lit = 7'h4F;
            4'h4:    lit = 7'h66;
            4'h5:    lit = 7'h6D;
            4'h6:    lit = 7'h7D;
            4'h7:    lit = 7'h07;
            4'h8:    lit = 7'h7F;
            4'h9:    lit = 7'h6F;
            4'hA:    lit = 7'h77;
            4'hB:    lit = 7'h7C;
            4'hC:    lit = 7'h39;
            4'hD:    lit = 7'h5E;
            4'hE:    lit = 7'h79;
            default: lit = 7'h71;
        endcase
        return lit;
    endfunction

    // Apply non-BCD blanking, then the pin polarity.
    function automatic logic [6:0] seg_drive(input logic [3:0] d);
        logic [6:0] lit;
        lit = seg_lit(d);
        if (BLANK_NON_BCD && (d > 4'd9)) begin
            lit = 7'h00;
        end
        return ACTIVE_LOW ? ~lit : lit;
    endfunction

    // ---- stage p0: combinational decode ----
    logic [3:0] digit_p0 [4];
    logic [6:0] seg_p0   [4];
    logic [6:0] hex_p1   [4];

    assign digit_p0[0] = out0;
    assign digit_p0[1] = out1;
    assign digit_p0[2] = out2;
    assign digit_p0[3] = out3;

    // Decode each channel independently.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            seg_p0[i] = seg_drive(digit_p0[i]);
        end
    end

    // ---- stage p1: output register ----
    // Register the patterns. Reset blanks the display at once, without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                hex_p1[i] <= BLANK;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                hex_p1[i] <= seg_p0[i];
            end
        end
    end

    assign Hex0 = hex_p1[0];
    assign Hex1 = hex_p1[1];
    assign Hex2 = hex_p1[2];
    assign Hex3 = hex_p1[3];

endmodule

// File: tb/tb_decoding_display.sv
// Scoreboard bench for decoding_display covering three parameter sets:
// the defaults, hex glyphs, and active-high polarity with hex glyphs.
// All three instances share the same inputs.
module tb_decoding_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] out0 = 4'h5, out1 = 4'hA, out2 = 4'h3, out3 = 4'hF;
    logic [6:0] df_h0, df_h1, df_h2, df_h3;
    logic [6:0] hx_h0, hx_h1, hx_h2, hx_h3;
    logic [6:0] ah_h0, ah_h1, ah_h2, ah_h3;

    int total = 0;
    int bad   = 0;

    typedef logic [11:0][6:0] exp_t;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    decoding_display dut (
        .clk(clk), .rst_n(rst_n), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .Hex0(df_h0), .Hex1(df_h1), .Hex2(df_h2), .Hex3(df_h3)
    );

    decoding_display #(.ACTIVE_LOW(1'b1), .BLANK_NON_BCD(1'b0)) dut_hex (
        .clk(clk), .rst_n(rst_n), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .Hex0(hx_h0), .Hex1(hx_h1), .Hex2(hx_h2), .Hex3(hx_h3)
    );

    decoding_display #(.ACTIVE_LOW(1'b0), .BLANK_NON_BCD(1'b0)) dut_ah (
        .clk(clk), .rst_n(rst_n), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .Hex0(ah_h0), .Hex1(ah_h1), .Hex2(ah_h2), .Hex3(ah_h3)
    );

    // Reference glyphs, active-high, bit6..bit0 = g..a.
    function automatic logic [6:0] ref_lit(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[d];
    endfunction

    function automatic logic [6:0] ref_code(input logic [3:0] d, input bit al, input bit blank);
        logic [6:0] lit;
        lit = (blank && d >= 4'd10) ? 7'h00 : ref_lit(d);
        return al ? ~lit : lit;
    endfunction

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Drive one input set and push what every instance must show after the next edge.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        logic [3:0] v [4];
        exp_t e;
        v = '{a, b, c, d};
        out0 = a; out1 = b; out2 = c; out3 = d;
        for (int i = 0; i < 4; i++) begin
            e[i]     = ref_code(v[i], 1'b1, 1'b1);
            e[4 + i] = ref_code(v[i], 1'b1, 1'b0);
            e[8 + i] = ref_code(v[i], 1'b0, 1'b0);
        end
        exp_q.push_back(e);
    endtask

    // Let one edge pass, then pop the scoreboard and compare all twelve outputs.
    task automatic settle(input string tag);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        got = '{ah_h3, ah_h2, ah_h1, ah_h0, hx_h3, hx_h2, hx_h1, hx_h0, df_h3, df_h2, df_h1, df_h0};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard empty got=%h want=entry", tag, got);
        end else begin
            total--;
            e = exp_q.pop_front();
            for (int i = 0; i < 12; i++) begin
                chk($sformatf("%s[%0d]", tag, i), got[i], e[i]);
            end
        end
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, "_df0"}, df_h0, 7'h7F); chk({tag, "_df1"}, df_h1, 7'h7F);
        chk({tag, "_df2"}, df_h2, 7'h7F); chk({tag, "_df3"}, df_h3, 7'h7F);
        chk({tag, "_hx0"}, hx_h0, 7'h7F); chk({tag, "_hx3"}, hx_h3, 7'h7F);
        chk({tag, "_ah0"}, ah_h0, 7'h00); chk({tag, "_ah1"}, ah_h1, 7'h00);
        chk({tag, "_ah2"}, ah_h2, 7'h00); chk({tag, "_ah3"}, ah_h3, 7'h00);
    endtask

    initial begin
        // Reset held with arbitrary inputs, across several edges.
        repeat (3) @(posedge clk);
        #1;
        chk_blank("reset");
        rst_n = 1'b1;

        // Opposing sweep: 9..0 against 0..9.
        for (int i = 0; i <= 9; i++) begin
            apply(4'(9 - i), 4'(i), 4'(9 - i), 4'(i));
            settle($sformatf("sweep%0d", i));
            if (i == 0) begin
                chk("sweep_first_h0", df_h0, 7'h10);
                chk("sweep_first_h1", df_h1, 7'h40);
            end
            if (i == 9) begin
                chk("sweep_last_h2", df_h2, 7'h40);
                chk("sweep_last_h3", df_h3, 7'h10);
            end
        end

        // Latency: a change just after an edge waits for the next edge.
        apply(4'd3, 4'd3, 4'd3, 4'd3);
        settle("lat_pre");
        chk("lat_pre_h0", df_h0, 7'h30);
        apply(4'd7, 4'd3, 4'd3, 4'd3);
        #3;
        chk("lat_hold_h0", df_h0, 7'h30);
        settle("lat_post");
        chk("lat_post_h0", df_h0, 7'h78);

        // Non-BCD codes blank on the default build.
        apply(4'd10, 4'd12, 4'd14, 4'd15);
        settle("nonbcd");
        chk("nonbcd_h0", df_h0, 7'h7F);
        chk("nonbcd_h3", df_h3, 7'h7F);

        // Hex glyphs and active-high patterns.
        apply(4'hA, 4'hF, 4'd8, 4'd1);
        settle("glyph");
        chk("glyphA_hx0", hx_h0, 7'h08);
        chk("glyphF_hx1", hx_h1, 7'h0E);
        chk("ah8_h2", ah_h2, 7'h7F);
        chk("ah1_h3", ah_h3, 7'h06);

        // Every code on every channel.
        for (int k = 0; k < 16; k++) begin
            apply(4'(k), 4'(k + 5), 4'(k + 10), 4'(k + 15));
            settle($sformatf("all%0d", k));
        end

        // Reset asserted between edges blanks without waiting for clk.
        apply(4'd8, 4'd8, 4'd8, 4'd8);
        settle("pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        chk_blank("midrst");
        @(posedge clk);
        #1;
        chk_blank("midrst_edge");
        rst_n = 1'b1;

        // First edge after release loads the decoded inputs.
        apply(4'd2, 4'd4, 4'd6, 4'hB);
        settle("release");

        // Random stimulus.
        for (int r = 0; r < 20; r++) begin
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            settle($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoding_display.md
Name: decoding_display

Overview:
Four-digit seven-segment decoder. It converts four 4-bit digit values, out0..out3, into four 7-segment drive patterns, Hex0..Hex3, for board displays. It sits between the counter/timer datapath and the HEX display pins. Outputs are registered so the display pins are glitch-free.

Parameters:
ACTIVE_LOW, 1, 1 = a lit segment is driven 0 (board HEX pins); 0 = a lit segment is driven 1.
BLANK_NON_BCD, 1, 1 = inputs 10..15 blank the digit; 0 = inputs 10..15 show hex glyphs A,b,C,d,E,F.

Ports:
clk    input   1  system clock; all outputs update on its rising edge.
rst_n  input   1  asynchronous, active-low reset.
out0   input   4  digit value for display 0.
out1   input   4  digit value for display 1.
out2   input   4  digit value for display 2.
out3   input   4  digit value for display 3.
Hex0   output  7  segment pattern for display 0; bit0=a, bit1=b, …, bit6=g.
Hex1   output  7  segment pattern for display 1; same bit order.
Hex2   output  7  segment pattern for display 2; same bit order.
Hex3   output  7  segment pattern for display 3; same bit order.

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous and active-low.
- Four identical, independent decode channels: outN -> HexN. There is no cross-coupling between channels.
- Combinational decode feeds an output register.
- Latency: HexN reflects the outN value sampled at the previous rising edge of clk. Latency is exactly 1 cycle.
- Reset: while rst_n = 0, all Hex outputs are forced to blank, asynchronously. Blank is 7'h7F when ACTIVE_LOW=1 and 7'h00 when ACTIVE_LOW=0.
- Release of reset: the first rising edge after rst_n goes high loads the decoded inputs.
- Reset asserted mid-operation: outputs blank immediately, with no wait for clk.
- Lit-segment patterns, written as active-high hex with bit6..bit0 = g..a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - A=77, b=7C, C=39, d=5E, E=79, F=71
- Polarity: when ACTIVE_LOW=1, every pattern (including blank) is bitwise inverted before the register. Examples: 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, 9 -> 7'h10.
- Inputs 10..15:
  - BLANK_NON_BCD=1: the digit is blank.
  - BLANK_NON_BCD=0: the digit shows the hex glyph from the table above.
- No X-propagation dependence: every 4-bit input code has a defined output.
- Input changes between clock edges have no effect until the next rising edge.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs -> all Hex = 7'h7F. Assert rst_n low mid-run, between edges -> all Hex = 7'h7F immediately.
- Opposing sweep, defaults: start out0=9, out1=0, out2=9, out3=0. Every 10 ns step out0/out2 down by 1 and out1/out3 up by 1, nine times. One cycle after each step:
  - Hex0 = Hex2 = the active-low code of the down-counting value.
  - Hex1 = Hex3 = the active-low code of the up-counting value.
  - Example first step: 9 -> 7'h10 and 0 -> 7'h40. Example final step: 0 -> 7'h40 and 9 -> 7'h10.
- Latency: change out0 from 3 to 7 just after an edge -> Hex0 stays 7'h30 until the next edge, then becomes 7'h78.
- Non-BCD values, defaults: out0..out3 = 10, 12, 14, 15 -> all Hex = 7'h7F.
- Hex glyphs: with BLANK_NON_BCD=0, out0=A -> Hex0 = 7'h08. With BLANK_NON_BCD=0, out1=F -> Hex1 = 7'h0E.
- Active-high polarity: with ACTIVE_LOW=0:
  - 8 -> 7'h7F.
  - 1 -> 7'h06.
  - During reset -> all Hex = 7'h00.
